// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encoding, FSM states and iteration count for the multiply/divide unit
package mdu_pkg;
    typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_e;
    localparam int ITERS = 32;
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one shift-add (div=0) or restoring-divide (div=1) iteration on {hi,lo} accumulator; ports acc, opnd, div -> acc_n
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               div,
    output logic [2*WIDTH-1:0] acc_n
);
    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] diff;
    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? opnd : {WIDTH{1'b0}}};
        diff  = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd};
        acc_n = div ? (diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                    : {sum, acc[WIDTH-1:1]};
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: 35-cycle iterative MULT/MULTU/DIV/DIVU owning HI/LO; in clk,rst,start,op,a,b,hi_we,lo_we,wdata; out busy,done,hi,lo
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(ITERS);
    state_e             state, state_n;
    op_e                op_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_n, prod, res;
    logic [WIDTH-1:0]   a_q, b_q, opnd, ma, mb, q_fix, r_fix;
    logic               neg_q, neg_r, signed_op, is_div;
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction
    assign signed_op = !op_q[0];
    assign is_div    = op_q[1];
    assign ma        = signed_op ? mag(a_q) : a_q;
    assign mb        = signed_op ? mag(b_q) : b_q;
    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc   (acc),
        .opnd  (opnd),
        .div   (is_div),
        .acc_n (acc_n)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state == IDLE ? (start ? PREP : IDLE)
                : state == PREP ? ITER
                : state == ITER ? (cnt == CW'(ITERS - 1) ? FIX : ITER)
                : IDLE;
    end
    // Divide by zero returns all-ones quotient and the raw dividend, skipping sign fix-up.
    always_comb begin
        prod  = neg_q ? -acc : acc;
        q_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res   = !is_div ? prod : (b_q == '0 ? {a_q, {WIDTH{1'b1}}} : {r_fix, q_fix});
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            acc   <= '0;
            opnd  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_MULT;
        end else begin
            busy <= state_n != IDLE;
            done <= state == FIX;
            if (state == IDLE && start) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op_e'(op);
            end
            // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
            if (state == PREP) begin
                acc   <= {{WIDTH{1'b0}}, is_div ? ma : mb};
                opnd  <= is_div ? mb : ma;
                neg_q <= signed_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_r <= signed_op & a_q[WIDTH-1];
                cnt   <= '0;
            end
            if (state == ITER) begin
                acc <= acc_n;
                cnt <= cnt + 1'b1;
            end
            if (state == FIX) begin
                {hi, lo} <= res;
            end else if (state == IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized scoreboard bench for mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst, start, hi_we, lo_we, busy, done;
    logic [1:0]  op;
    logic [31:0] a, b, wdata, hi, lo;
    int          n_cmp = 0, n_err = 0;
    logic [63:0] sb[$];
    always #5 clk = ~clk;
    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        logic [63:0] ux = {32'b0, x};
        logic [63:0] uy = {32'b0, y};
        logic [63:0] q, r;
        if (o[1] && y == 32'd0) return {x, 32'hFFFF_FFFF};
        case (o)
            2'b00: return sx * sy;
            2'b01: return ux * uy;
            2'b10: begin q = sx / sy; r = sx % sy; return {r[31:0], q[31:0]}; end
            default: begin q = ux / uy; r = ux % uy; return {r[31:0], q[31:0]}; end
        endcase
    endfunction
    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask
    task automatic monitor();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) check("done_without_issue", {63'b0, done}, 64'd0);
                else begin
                    e = sb.pop_front();
                    check("hi_lo", {hi, lo}, e);
                end
            end
        end
    endtask
    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", {63'b0, busy}, 64'd0);
    endtask
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        wait_idle();
        op = o; a = x; b = y; start = 1'b1;
        sb.push_back(model(o, x, y));
        @(posedge clk);
        #1 start = 1'b0; a = $urandom; b = $urandom;
    endtask
    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction
    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = 2'b00; a = '0; b = '0; wdata = '0;
        fork monitor(); join_none
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", {62'(0), busy, done} | 64'({hi, lo} != 64'd0), 64'd0);
        // MULTU 0xFFFFFFFF^2 with cycle-exact busy/done timing
        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        sb.push_back(64'hFFFF_FFFE_0000_0001);
        @(posedge clk);
        #1 start = 1'b0; a = $urandom; b = $urandom;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            check($sformatf("busy_T+%0d", i), {62'(0), busy, done}, 64'b10);
            if (i == 20) check("hold_mid_op", {hi, lo}, 64'd0);
        end
        @(negedge clk);
        check("done_T+35", {62'(0), busy, done}, 64'b01);
        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b11, 32'd100, 32'd0);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE);
        issue(2'b10, 32'hFFFF_FFF0, 32'd0);
        issue(2'b11, 32'hFFFF_FFFF, 32'h8000_0001);
        for (int i = 0; i < 80; i++) issue(2'($urandom_range(0, 3)), pick(), pick());
        drain();
        // abort: reset lands on edge T+10
        issue(2'b01, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", {62'(0), busy, done} | 64'({hi, lo} != 64'd0), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen |= int'(done);
        end
        check("no_done_after_abort", 64'(seen), 64'd0);
        hi_we = 1'b1; wdata = 32'h1234;
        @(posedge clk);
        #1 hi_we = 1'b0;
        @(negedge clk);
        check("mthi", {hi, lo}, {32'h1234, 32'h0});
        // start and idle writes issued while busy must be ignored
        issue(2'b11, 32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3; lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD;
        repeat (3) @(negedge clk);
        start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
        drain();
        // start together with an idle write: write lands now, result lands later
        wait_idle();
        op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1; lo_we = 1'b1; wdata = 32'hABCD;
        sb.push_back(model(2'b01, 32'd3, 32'd4));
        @(posedge clk);
        #1 start = 1'b0; lo_we = 1'b0;
        @(negedge clk);
        check("mtlo_with_start", {hi, lo}, {32'd6, 32'hABCD});
        drain();
        repeat (40) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
